// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad-matrix front end.
package keypad_pkg;

  localparam int KEYS_PER_PAD = 12;

  // Key indices of the bottom row; keys 1..9 are indices 0..8.
  localparam int K_STAR = 9;
  localparam int K_ZERO = 10;
  localparam int K_HASH = 11;

  // Result of a PS/2 scan-code lookup.
  typedef struct packed {
    logic       valid;
    logic [1:0] pad;
    logic [3:0] key;
  } key_map_t;

  // Builds a valid map entry for the given pad and key index.
  function automatic key_map_t map_hit(input logic [1:0] pad, input logic [3:0] key);
    key_map_t m;
    m.valid = 1'b1;
    m.pad   = pad;
    m.key   = key;
    return m;
  endfunction

endpackage

// File: rtl/ps2_keypad_map.sv
// PS/2 scan code to {pad, key} lookup. code[8] is the extended (E0) flag.
// Pad 0 is the numeric keypad, pad 1 the main-row digits.
module ps2_keypad_map
  import keypad_pkg::*;
(
  input  logic [8:0] code,
  output key_map_t   map
);

  // Fixed layout table; anything not listed is reported as invalid.
  always_comb begin
    map = '0;
    case (code)
      9'h069: map = map_hit(2'd0, 4'd0);
      9'h072: map = map_hit(2'd0, 4'd1);
      9'h07A: map = map_hit(2'd0, 4'd2);
      9'h06B: map = map_hit(2'd0, 4'd3);
      9'h073: map = map_hit(2'd0, 4'd4);
      9'h074: map = map_hit(2'd0, 4'd5);
      9'h06C: map = map_hit(2'd0, 4'd6);
      9'h075: map = map_hit(2'd0, 4'd7);
      9'h07D: map = map_hit(2'd0, 4'd8);
      9'h070: map = map_hit(2'd0, 4'(K_ZERO));
      9'h07C: map = map_hit(2'd0, 4'(K_STAR));
      9'h071: map = map_hit(2'd0, 4'(K_STAR));
      9'h07B: map = map_hit(2'd0, 4'(K_HASH));
      9'h15A: map = map_hit(2'd0, 4'(K_HASH));
      9'h016: map = map_hit(2'd1, 4'd0);
      9'h01E: map = map_hit(2'd1, 4'd1);
      9'h026: map = map_hit(2'd1, 4'd2);
      9'h025: map = map_hit(2'd1, 4'd3);
      9'h02E: map = map_hit(2'd1, 4'd4);
      9'h036: map = map_hit(2'd1, 4'd5);
      9'h03D: map = map_hit(2'd1, 4'd6);
      9'h03E: map = map_hit(2'd1, 4'd7);
      9'h046: map = map_hit(2'd1, 4'd8);
      9'h045: map = map_hit(2'd1, 4'(K_ZERO));
      9'h04E: map = map_hit(2'd1, 4'(K_STAR));
      9'h055: map = map_hit(2'd1, 4'(K_HASH));
      default: map = '0;
    endcase
  end

endmodule

// File: rtl/keypad_matrix_ctrl.sv
// Keypad-matrix front end: PS/2 keys and debounced joystick buttons merged
// into per-pad 12-key states, presented as active-low rows for the
// column-scanned PPI input. Short keyboard presses are stretched until a CPU
// read of their column has seen them.
module keypad_matrix_ctrl
  import keypad_pkg::*;
#(
  parameter int NUM_PADS     = 2,
  parameter int COLS         = 3,
  parameter int ROWS         = 4,
  parameter int JOY_DEBOUNCE = 8
) (
  input  logic                         clk_3m58,
  input  logic                         reset,
  input  logic [10:0]                  ps2_key,
  input  logic [NUM_PADS*12-1:0]       joy,
  input  logic [COLS-1:0]              col_n,
  input  logic                         rd_strobe,
  output logic [NUM_PADS*ROWS-1:0]     row_n,
  output logic                         key_any
);

  localparam int NKEYS = NUM_PADS * KEYS_PER_PAD;
  localparam int CNT_W = (JOY_DEBOUNCE > 0) ? $clog2(JOY_DEBOUNCE + 1) : 1;

  logic                     tog_q, tog_d;
  logic                     ps2_evt;
  logic                     pad_ok;
  key_map_t                 map;
  logic [NKEYS-1:0]         key_hit, key_smp;
  logic [NKEYS-1:0]         held_q, held_d;
  logic [NKEYS-1:0]         smp_q, smp_d;
  logic [NKEYS-1:0]         pend_q, pend_d;
  logic [NKEYS-1:0]         joy_stb;
  logic [NKEYS-1:0]         eff;
  logic [NUM_PADS*ROWS-1:0] row_n_q, row_n_d;
  logic                     key_any_q, key_any_d;

  ps2_keypad_map u_map (
    .code (ps2_key[8:0]),
    .map  (map)
  );

  // A PS/2 event is any change of the toggle bit; codes for absent pads are dropped.
  always_comb begin
    tog_d   = ps2_key[10];
    ps2_evt = ps2_key[10] ^ tog_q;
    pad_ok  = map.valid && (32'(map.pad) < NUM_PADS);
  end

  // Per-key decode of the current event and of a CPU read covering the key's column.
  always_comb begin
    key_hit = '0;
    key_smp = '0;
    for (int i = 0; i < NKEYS; i++) begin
      key_hit[i] = ps2_evt && pad_ok &&
                   (map.pad == 2'(i / KEYS_PER_PAD)) &&
                   (map.key == 4'(i % KEYS_PER_PAD));
      key_smp[i] = rd_strobe && !col_n[(i % KEYS_PER_PAD) % COLS] && held_q[i];
    end
  end

  // Press arms a key; a release only drops it once a read has seen the press.
  always_comb begin
    held_d = held_q;
    smp_d  = smp_q;
    pend_d = pend_q;
    for (int i = 0; i < NKEYS; i++) begin
      smp_d[i] = smp_q[i] | key_smp[i];
      if (key_hit[i] && ps2_key[9]) begin
        held_d[i] = 1'b1;
        smp_d[i]  = 1'b0;
        pend_d[i] = 1'b0;
      end else if (key_hit[i]) begin
        if (smp_d[i]) held_d[i] = 1'b0;
        else          pend_d[i] = 1'b1;
      end
      if (smp_d[i] && pend_d[i]) begin
        held_d[i] = 1'b0;
        pend_d[i] = 1'b0;
      end
    end
  end

  // Joystick debounce: the stable bit follows the raw bit only after it has
  // differed for JOY_DEBOUNCE+1 consecutive samples (one sample when bypassed).
  for (genvar b = 0; b < NKEYS; b++) begin : g_deb
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stb_q, stb_d;

    // Count consecutive disagreements and flip once the limit is reached.
    always_comb begin
      cnt_d = cnt_q;
      stb_d = stb_q;
      if (joy[b] == stb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(JOY_DEBOUNCE)) begin
        stb_d = ~stb_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Debounce state register.
    always_ff @(posedge clk_3m58) begin
      if (reset) begin
        cnt_q <= '0;
        stb_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        stb_q <= stb_d;
      end
    end

    assign joy_stb[b] = stb_q;
  end

  // Row word: a row goes low when any selected column holds an effective key.
  always_comb begin
    eff       = held_q | joy_stb;
    row_n_d   = '1;
    key_any_d = |eff;
    for (int p = 0; p < NUM_PADS; p++) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (!col_n[c] && eff[p*KEYS_PER_PAD + r*COLS + c]) row_n_d[p*ROWS + r] = 1'b0;
        end
      end
    end
  end

  // Key-state and output registers; the toggle history reloads on reset so
  // a toggle level left over from before reset is not taken as an event.
  always_ff @(posedge clk_3m58) begin
    if (reset) begin
      tog_q     <= ps2_key[10];
      held_q    <= '0;
      smp_q     <= '0;
      pend_q    <= '0;
      row_n_q   <= '1;
      key_any_q <= 1'b0;
    end else begin
      tog_q     <= tog_d;
      held_q    <= held_d;
      smp_q     <= smp_d;
      pend_q    <= pend_d;
      row_n_q   <= row_n_d;
      key_any_q <= key_any_d;
    end
  end

  assign row_n   = row_n_q;
  assign key_any = key_any_q;

endmodule

// File: tb/tb_keypad_matrix_ctrl.sv
// Bench for keypad_matrix_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the key rules.
module tb_keypad_matrix_ctrl;

  localparam int JD = 8;
  localparam int NK = 24;
  localparam int NC = 29;

  localparam logic [8:0] PAD0 [12] = '{9'h069, 9'h072, 9'h07A, 9'h06B, 9'h073, 9'h074,
                                       9'h06C, 9'h075, 9'h07D, 9'h07C, 9'h070, 9'h07B};
  localparam logic [8:0] PAD1 [12] = '{9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036,
                                       9'h03D, 9'h03E, 9'h046, 9'h04E, 9'h045, 9'h055};
  localparam logic [8:0] CODES [NC] = '{9'h069, 9'h072, 9'h07A, 9'h06B, 9'h073, 9'h074,
                                        9'h06C, 9'h075, 9'h07D, 9'h070, 9'h07C, 9'h071,
                                        9'h07B, 9'h15A, 9'h016, 9'h01E, 9'h026, 9'h025,
                                        9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046, 9'h045,
                                        9'h04E, 9'h055, 9'h029, 9'h05A, 9'h169};

  logic        clk_3m58 = 1'b0;
  logic        reset;
  logic [10:0] ps2_key, ps2_key1;
  logic [NK-1:0] joy;
  logic [11:0] joy1;
  logic [2:0]  col_n;
  logic        rd_strobe;
  logic [7:0]  row_n;
  logic        key_any;
  logic [3:0]  row_n1;
  logic        key_any1;

  always #140 clk_3m58 = ~clk_3m58;

  keypad_matrix_ctrl #(.NUM_PADS(2), .COLS(3), .ROWS(4), .JOY_DEBOUNCE(JD)) u_dut (
    .clk_3m58  (clk_3m58),
    .reset     (reset),
    .ps2_key   (ps2_key),
    .joy       (joy),
    .col_n     (col_n),
    .rd_strobe (rd_strobe),
    .row_n     (row_n),
    .key_any   (key_any)
  );

  keypad_matrix_ctrl #(.NUM_PADS(1), .COLS(3), .ROWS(4), .JOY_DEBOUNCE(JD)) u_dut1 (
    .clk_3m58  (clk_3m58),
    .reset     (reset),
    .ps2_key   (ps2_key1),
    .joy       (joy1),
    .col_n     (col_n),
    .rd_strobe (rd_strobe),
    .row_n     (row_n1),
    .key_any   (key_any1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Flat key number (pad*12 + key) for a scan code, or -1 when unmapped.
  function automatic int key_of(input logic [8:0] code);
    for (int k = 0; k < 12; k++) begin
      if (code == PAD0[k]) return k;
      if (code == PAD1[k]) return 12 + k;
    end
    if (code == 9'h071) return 9;
    if (code == 9'h15A) return 11;
    return -1;
  endfunction

  // Reference model state.
  bit            m_held [NK];
  bit            m_smp  [NK];
  bit            m_pend [NK];
  bit            m_stb  [NK];
  logic [JD:0]   m_hist [NK];
  bit            m_tog;
  logic [7:0]    exp_row = 8'hFF;
  bit            exp_any = 1'b0;
  bit            mon_en  = 1'b0;

  // Model: outputs follow the state held before each edge; state then
  // advances from the inputs seen at that edge.
  always @(posedge clk_3m58) begin : model
    bit eff [NK];
    int idx;
    bit sample;
    if (reset) begin
      for (int i = 0; i < NK; i++) begin
        m_held[i] = 0; m_smp[i] = 0; m_pend[i] = 0; m_stb[i] = 0; m_hist[i] = '0;
      end
      m_tog   = ps2_key[10];
      exp_row = 8'hFF;
      exp_any = 1'b0;
    end else begin
      for (int i = 0; i < NK; i++) eff[i] = m_held[i] | m_stb[i];
      exp_row = 8'hFF;
      exp_any = 1'b0;
      for (int p = 0; p < 2; p++)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 3; c++)
            if (col_n[c] == 1'b0 && eff[p*12 + r*3 + c]) exp_row[p*4 + r] = 1'b0;
      for (int i = 0; i < NK; i++) exp_any = exp_any | eff[i];

      idx   = (ps2_key[10] != m_tog) ? key_of(ps2_key[8:0]) : -1;
      m_tog = ps2_key[10];
      for (int i = 0; i < NK; i++) begin
        sample = rd_strobe && (col_n[i % 3] == 1'b0) && m_held[i];
        if (i == idx && ps2_key[9]) begin
          m_held[i] = 1; m_smp[i] = 0; m_pend[i] = 0;
        end else if (i == idx) begin
          if (m_smp[i] || sample) m_held[i] = 0;
          else                    m_pend[i] = 1;
          if (sample) m_smp[i] = 1;
        end else if (sample) begin
          m_smp[i] = 1;
        end
        if (m_smp[i] && m_pend[i]) begin
          m_held[i] = 0; m_pend[i] = 0;
        end
      end

      for (int i = 0; i < NK; i++) begin
        m_hist[i] = {m_hist[i][JD-1:0], joy[i]};
        if (m_hist[i] == {(JD+1){~m_stb[i]}}) m_stb[i] = ~m_stb[i];
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk_3m58) begin
    if (mon_en) begin
      check_eq("model_row_n", {24'd0, row_n}, {24'd0, exp_row});
      check_eq("model_key_any", {31'd0, key_any}, {31'd0, exp_any});
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_3m58);
  endtask

  task automatic send(input logic [8:0] code, input bit pressed);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  task automatic send1(input logic [8:0] code, input bit pressed);
    ps2_key1 = {~ps2_key1[10], pressed, code};
  endtask

  initial begin
    reset = 1'b1; ps2_key = '0; ps2_key1 = '0; joy = '0; joy1 = '0;
    col_n = 3'b111; rd_strobe = 1'b0;
    tick(3);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reset state and first keypad press.
    col_n = 3'b110;
    tick(2);
    check_eq("rst_row_n", row_n, 8'hFF);
    check_eq("rst_key_any", key_any, 0);
    send(9'h069, 1'b1);
    tick();
    check_eq("press_lat1_row0", row_n[0], 1);
    tick();
    check_eq("press_row0", row_n[0], 0);
    check_eq("press_key_any", key_any, 1);

    // Release after the key has already been read.
    rd_strobe = 1'b1; tick(); rd_strobe = 1'b0;
    send(9'h069, 1'b0);
    tick();
    check_eq("rel_smp_lat1_row0", row_n[0], 0);
    tick();
    check_eq("rel_smp_row0", row_n[0], 1);
    check_eq("rel_smp_key_any", key_any, 0);

    // Short press on pad 1 key 5, stretched until a read of column 1.
    col_n = 3'b111;
    send(9'h02E, 1'b1); tick();
    send(9'h02E, 1'b0); tick(3);
    check_eq("short_held_any", key_any, 1);
    check_eq("short_nocol_row", row_n, 8'hFF);
    col_n = 3'b101; tick();
    check_eq("short_col_row5", row_n[5], 0);
    rd_strobe = 1'b1; tick(); rd_strobe = 1'b0;
    check_eq("short_read_row5", row_n[5], 0);
    tick();
    check_eq("short_rel_row5", row_n[5], 1);
    check_eq("short_rel_any", key_any, 0);

    // Joystick pad 0 '#': 7-cycle pulse filtered, 9-cycle pulse passes at cycle 10.
    col_n = 3'b011;
    joy[11] = 1'b1; tick(7); joy[11] = 1'b0;
    tick(12);
    check_eq("joy_short_row3", row_n[3], 1);
    check_eq("joy_short_any", key_any, 0);
    joy[11] = 1'b1; tick(9);
    check_eq("joy_lat9_row3", row_n[3], 1);
    joy[11] = 1'b0; tick();
    check_eq("joy_lat10_row3", row_n[3], 0);
    tick(12);
    check_eq("joy_off_row3", row_n[3], 1);

    // Two columns selected, then none.
    col_n = 3'b100;
    send(9'h069, 1'b1); tick();
    send(9'h072, 1'b1); tick(2);
    check_eq("multi_row0", row_n[0], 0);
    check_eq("multi_row_hi", row_n[7:1], 7'h7F);
    col_n = 3'b111; tick();
    check_eq("nocol_row_n", row_n, 8'hFF);
    check_eq("nocol_key_any", key_any, 1);
    col_n = 3'b100; rd_strobe = 1'b1; tick(); rd_strobe = 1'b0;
    send(9'h069, 1'b0); tick();
    send(9'h072, 1'b0); tick(2);
    check_eq("multi_rel_any", key_any, 0);

    // Unmapped code and a pad-1 code on a single-pad instance.
    col_n = 3'b000;
    send(9'h029, 1'b1); tick(3);
    check_eq("unmapped_row_n", row_n, 8'hFF);
    check_eq("unmapped_any", key_any, 0);
    send1(9'h016, 1'b1); tick(3);
    check_eq("np1_pad1_row_n", row_n1, 4'hF);
    check_eq("np1_pad1_any", key_any1, 0);
    send1(9'h069, 1'b1); tick(2);
    check_eq("np1_pad0_row0", row_n1[0], 0);

    // Reset in the middle of a hold.
    send(9'h070, 1'b1); tick(2);
    check_eq("hold_row3", row_n[3], 0);
    reset = 1'b1; tick();
    check_eq("rst_hold_row_n", row_n, 8'hFF);
    check_eq("rst_hold_any", key_any, 0);
    reset = 1'b0; tick(3);
    check_eq("rst_stays_row_n", row_n, 8'hFF);
    check_eq("rst_stays_np1", row_n1, 4'hF);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) send(CODES[$urandom_range(0, NC-1)], 1'($urandom_range(0, 1)));
      col_n     = 3'($urandom);
      rd_strobe = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < NK; b++) if ($urandom_range(0, 9) == 0) joy[b] = ~joy[b];
      reset     = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0; rd_strobe = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
